register_file: RTL

- Architectural register file with rename tracking, for the RV32I out-of-order core.
- Downstream of the reorder buffer: consumes its commit stream (regUpdateValid/Dest/Value/RobId) and writes x1..x31.
- Tracks, per register, whether a younger in-flight instruction owns it and which ROB entry that is.
- Serves two operand reads for the instruction unit, forwarding from the ROB when the register is dirty.

---
 rtl/register_file_pkg.sv | 16 +
 rtl/reg_file_read_port.sv | 41 ++++
 rtl/register_file.sv | 81 ++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared constants for the architectural register file.
// Contents:
//    ROB_WIDTH_DEFAULT - default ROB index width
//    REG_NUM_DEFAULT   - number of architectural registers
//    REG_ADDR_WIDTH    - register number width
//    ZERO_REG          - hard-wired zero register x0
//    isZeroReg()       - true for x0
package register_file_pkg;
   localparam int ROB_WIDTH_DEFAULT = 4;
   localparam int REG_NUM_DEFAULT = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
   function automatic logic isZeroReg(input logic [REG_ADDR_WIDTH-1:0] addr);
      return addr == ZERO_REG;
   endfunction
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one operand read port with x0 handling, commit bypass and ROB forwarding.
// Ports:
//    rsAddr                                 - source register number
//    regIn / dirtyIn / tagIn                - architectural state of that register
//    commitValid/Dest/RobId/Value           - commit stream from the ROB (bypass source)
//    robReady / robValue                    - ROB lookup result for rsDep
//    rsDep / rsDirty / rsReady / rsValue    - operand result
// BYPASS_EN selects same-cycle commit forwarding.
module reg_file_read_port
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT,
   parameter bit BYPASS_EN = 1'b0
) (
   input  logic [REG_ADDR_WIDTH-1:0] rsAddr,
   input  logic [31:0]               regIn,
   input  logic                      dirtyIn,
   input  logic [ROB_WIDTH-1:0]      tagIn,
   input  logic                      commitValid,
   input  logic [REG_ADDR_WIDTH-1:0] commitDest,
   input  logic [ROB_WIDTH-1:0]      commitRobId,
   input  logic [31:0]               commitValue,
   input  logic                      robReady,
   input  logic [31:0]               robValue,
   output logic [ROB_WIDTH-1:0]      rsDep,
   output logic                      rsDirty,
   output logic                      rsReady,
   output logic [31:0]               rsValue
);
   logic isZero;
   logic bypassHit;
   always_comb begin
      isZero = isZeroReg(rsAddr);
      // Forward the commit only when it retires the very instruction that owns the register.
      bypassHit = BYPASS_EN && commitValid && commitDest == rsAddr && commitRobId == tagIn;
      rsDep = tagIn;
      rsDirty = !isZero && dirtyIn;
      rsReady = !rsDirty || bypassHit || robReady;
      rsValue = isZero ? 32'd0 : !rsDirty ? regIn : bypassHit ? commitValue : robValue;
   end
endmodule

// File: rtl/register_file.sv
// register_file: RV32I architectural register file with rename tracking and two forwarding read ports.
// Ports:
//    clockIn, resetIn (async, active-low), readyIn (global enable), clear (flush)
//    regUpdateValid/Dest/regValue/regUpdateRobId - ROB commit stream
//    renameValid/Dest/RobId                      - destination claim from the instruction unit
//    rs1Addr/rs2Addr                             - source register numbers
//    rs1Dep/rs2Dep                               - owning ROB tag, to the ROB lookup
//    robRs1Ready/Value, robRs2Ready/Value        - ROB lookup results
//    rs1Dirty/Ready/Value, rs2Dirty/Ready/Value  - operand results
// Define REGFILE_COMMIT_BYPASS_EN to forward a same-cycle commit to the read ports.
module register_file
   import register_file_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT,
   parameter int REG_NUM = REG_NUM_DEFAULT
) (
   input  logic                      clockIn,
   input  logic                      resetIn,
   input  logic                      readyIn,
   input  logic                      clear,
   input  logic                      regUpdateValid,
   input  logic [REG_ADDR_WIDTH-1:0] regUpdateDest,
   input  logic [31:0]               regValue,
   input  logic [ROB_WIDTH-1:0]      regUpdateRobId,
   input  logic                      renameValid,
   input  logic [REG_ADDR_WIDTH-1:0] renameDest,
   input  logic [ROB_WIDTH-1:0]      renameRobId,
   input  logic [REG_ADDR_WIDTH-1:0] rs1Addr,
   input  logic [REG_ADDR_WIDTH-1:0] rs2Addr,
   output logic [ROB_WIDTH-1:0]      rs1Dep,
   output logic [ROB_WIDTH-1:0]      rs2Dep,
   input  logic                      robRs1Ready,
   input  logic                      robRs2Ready,
   input  logic [31:0]               robRs1Value,
   input  logic [31:0]               robRs2Value,
   output logic                      rs1Dirty,
   output logic                      rs2Dirty,
   output logic                      rs1Ready,
   output logic                      rs2Ready,
   output logic [31:0]               rs1Value,
   output logic [31:0]               rs2Value
);
`ifdef REGFILE_COMMIT_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif
   logic [31:0]          regs [REG_NUM];
   logic [ROB_WIDTH-1:0] tag [REG_NUM];
   logic [REG_NUM-1:0]   dirty;
   // Later non-blocking writes win: rename beats the commit's dirty-clear, clear beats both.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         regs <= '{default: '0};
         tag <= '{default: '0};
         dirty <= '0;
      end else if (readyIn) begin
         if (regUpdateValid && !isZeroReg(regUpdateDest)) begin
            regs[regUpdateDest] <= regValue;
            if (dirty[regUpdateDest] && tag[regUpdateDest] == regUpdateRobId) dirty[regUpdateDest] <= 1'b0;
         end
         if (clear) dirty <= '0;
         else if (renameValid && !isZeroReg(renameDest)) begin
            dirty[renameDest] <= 1'b1;
            tag[renameDest] <= renameRobId;
         end
      end
   end
   reg_file_read_port #(.ROB_WIDTH(ROB_WIDTH), .BYPASS_EN(BYPASS_EN)) readPort1 (
      .rsAddr(rs1Addr), .regIn(regs[rs1Addr]), .dirtyIn(dirty[rs1Addr]), .tagIn(tag[rs1Addr]),
      .commitValid(regUpdateValid), .commitDest(regUpdateDest), .commitRobId(regUpdateRobId),
      .commitValue(regValue), .robReady(robRs1Ready), .robValue(robRs1Value),
      .rsDep(rs1Dep), .rsDirty(rs1Dirty), .rsReady(rs1Ready), .rsValue(rs1Value)
   );
   reg_file_read_port #(.ROB_WIDTH(ROB_WIDTH), .BYPASS_EN(BYPASS_EN)) readPort2 (
      .rsAddr(rs2Addr), .regIn(regs[rs2Addr]), .dirtyIn(dirty[rs2Addr]), .tagIn(tag[rs2Addr]),
      .commitValid(regUpdateValid), .commitDest(regUpdateDest), .commitRobId(regUpdateRobId),
      .commitValue(regValue), .robReady(robRs2Ready), .robValue(robRs2Value),
      .rsDep(rs2Dep), .rsDirty(rs2Dirty), .rsReady(rs2Ready), .rsValue(rs2Value)
   );
endmodule
